// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer between instruction memory and decode.
// Fetch and hold do not overlap: at most one instruction every two cycles.
module pc_fetch_sequencer #(
    parameter int                ADDR_W       = 64,
    parameter int                INSTR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] inst,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               dec_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               halted
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic [ADDR_W-1:0]  inst_pc_q, inst_pc_d;
    logic [INSTR_W-1:0] inst_q, inst_d;
    logic               redir_pend_q, redir_pend_d;
    logic               halt_pend_q, halt_pend_d;
    logic               halt_any;
    logic [ADDR_W-1:0]  redir_target;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

    assign halt_any     = halt | halt_pend_q;
    assign redir_target = align_pc(redirect_pc);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        redir_pend_d = redir_pend_q;
        halt_pend_d  = halt_pend_q | halt;
        case (state_q)
            S_IDLE: begin
                if (redirect) pc_d = redir_target;
                state_d = halt_any ? S_HALT : S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (!redir_pend_q && !redirect) begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + ADDR_W'(4);
                        state_d   = halt_any ? S_HALT : S_VALID;
                    end else begin
                        // Redirected transaction: drop the data, restart at the newest target.
                        pc_d         = redirect ? redir_target : tgt_q;
                        redir_pend_d = 1'b0;
                        state_d      = halt_any ? S_HALT : S_REQ;
                    end
                end else if (redirect) begin
                    // The request stays up at the old address until memory acks it.
                    tgt_d        = redir_target;
                    redir_pend_d = 1'b1;
                end
            end
            S_VALID: begin
                if (redirect) begin
                    pc_d    = redir_target;
                    state_d = (dec_ready && halt_any) ? S_HALT : S_REQ;
                end else if (dec_ready) begin
                    state_d = halt_any ? S_HALT : S_REQ;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_VECTOR;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            redir_pend_q <= 1'b0;
            halt_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            redir_pend_q <= redir_pend_d;
            halt_pend_q  <= halt_pend_d;
        end
    end

    // Target is only consumed while redir_pend_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        tgt_q <= tgt_d;
    end

    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == S_VALID);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios followed by a randomized run
// checked against an instruction-stream reference model.
module tb_pc_fetch_sequencer;

    localparam int          AW = 64;
    localparam int          IW = 32;
    localparam logic [63:0] RV = 64'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          inst_valid;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          dec_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    logic          halted;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .RESET_VECTOR(RV)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .dec_ready(dec_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_f(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic drv(input logic a, input logic r, input logic rd, input logic [63:0] rp, input logic h);
        imem_ack    = a;
        imem_rdata  = a ? mem_f(imem_addr) : 32'hDEAD_BEEF;
        dec_ready   = r;
        redirect    = rd;
        redirect_pc = rp;
        halt        = h;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"},    64'(imem_req),   64'd0);
        chk({tag, "_valid"},  64'(inst_valid), 64'd0);
        chk({tag, "_halted"}, 64'(halted),     64'd0);
        chk({tag, "_inst"},   64'(inst),       64'd0);
        chk({tag, "_instpc"}, inst_pc,         64'd0);
        chk({tag, "_addr"},   imem_addr,       RV);
    endtask

    logic [63:0] exp_pc, prev_addr, prev_pc;
    logic [31:0] prev_inst;
    logic        prev_wait, prev_hold, prev_leave;
    int          delivered;

    initial begin
        rst = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        nxt(); chk_reset_outs("rst_a");
        nxt(); chk_reset_outs("rst_b");
        rst = 1'b0;

        // Sequential fetch, memory acks immediately, decode always ready.
        for (int k = 0; k < 8; k++) begin
            nxt();
            if (k % 2 == 0) begin
                chk("seq_req",   64'(imem_req),   64'd1);
                chk("seq_valid", 64'(inst_valid), 64'd0);
                chk("seq_addr",  imem_addr,       64'(4 * (k / 2)));
            end else begin
                chk("seq_req",    64'(imem_req),   64'd0);
                chk("seq_valid",  64'(inst_valid), 64'd1);
                chk("seq_instpc", inst_pc,         64'(4 * (k / 2)));
                chk("seq_inst",   64'(inst),       64'(mem_f(64'(4 * (k / 2)))));
            end
            drv(imem_req, 1'b1, 1'b0, 64'h0, 1'b0);
        end

        nxt(); rst = 1'b1; drv(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        nxt(); chk_reset_outs("rst_c"); rst = 1'b0;

        // Redirect before ack: old request held, then discarded.
        nxt(); chk("rb_req", 64'(imem_req), 64'd1); chk("rb_addr0", imem_addr, 64'h0);
        drv(1'b0, 1'b0, 1'b1, 64'h1003, 1'b0);
        nxt(); chk("rb_hold_req", 64'(imem_req), 64'd1); chk("rb_hold_addr", imem_addr, 64'h0);
        drv(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        // Redirect in the same cycle as ack.
        nxt(); chk("rb_valid", 64'(inst_valid), 64'd0); chk("rb_addr", imem_addr, 64'h1000);
        drv(1'b1, 1'b0, 1'b1, 64'h2003, 1'b0);
        nxt(); chk("rc_valid", 64'(inst_valid), 64'd0); chk("rc_addr", imem_addr, 64'h2000);
        drv(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        // Redirect while holding, decode not ready.
        nxt(); chk("ra_valid", 64'(inst_valid), 64'd1); chk("ra_instpc", inst_pc, 64'h2000);
        drv(1'b0, 1'b0, 1'b1, 64'h1003, 1'b0);
        nxt(); chk("ra_drop", 64'(inst_valid), 64'd0); chk("ra_addr", imem_addr, 64'h1000);
        chk("ra_req", 64'(imem_req), 64'd1);

        // Halt during a pending request.
        drv(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        nxt(); chk("h_req", 64'(imem_req), 64'd1); chk("h_addr", imem_addr, 64'h1000);
        chk("h_not_yet", 64'(halted), 64'd0);
        drv(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        nxt(); chk("h_halted", 64'(halted), 64'd1); chk("h_req0", 64'(imem_req), 64'd0);
        chk("h_valid0", 64'(inst_valid), 64'd0); chk("h_pc", imem_addr, 64'h1004);
        drv(1'b1, 1'b1, 1'b1, 64'h3000, 1'b0);
        nxt(); chk("h_stay", 64'(halted), 64'd1); chk("h_req_stay", 64'(imem_req), 64'd0);
        chk("h_redir_ign", imem_addr, 64'h1004);
        rst = 1'b1; drv(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        nxt(); chk_reset_outs("h_rst"); rst = 1'b0;

        // Reset mid-transaction and while holding; late ack ignored.
        nxt(); chk("m_req", 64'(imem_req), 64'd1); rst = 1'b1;
        nxt(); chk_reset_outs("m_rst1"); rst = 1'b0; drv(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        nxt(); chk("m_late_req", 64'(imem_req), 64'd1); chk("m_late_valid", 64'(inst_valid), 64'd0);
        drv(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        nxt(); chk("m_valid", 64'(inst_valid), 64'd1); chk("m_instpc", inst_pc, 64'h0);
        rst = 1'b1; drv(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        nxt(); chk_reset_outs("m_rst2"); rst = 1'b0;

        // Wrap-around from the top of the address space.
        drv(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        nxt(); chk("w_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        drv(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        nxt(); chk("w_instpc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("w_inst", 64'(inst), 64'(mem_f(64'hFFFF_FFFF_FFFF_FFFC)));
        drv(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        nxt(); chk("w_req", 64'(imem_req), 64'd1); chk("w_addr1", imem_addr, 64'h0);
        drv(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);

        // Randomized run against the instruction-stream model.
        exp_pc = 64'h0; delivered = 0;
        prev_wait = 1'b0; prev_hold = 1'b0; prev_leave = 1'b0;
        prev_addr = '0; prev_pc = '0; prev_inst = '0;
        for (int c = 0; c < 1500; c++) begin
            nxt();
            chk("r_halted", 64'(halted), 64'd0);
            chk("r_excl", 64'(imem_req & inst_valid), 64'd0);
            if (prev_wait) begin
                chk("r_wait_req",  64'(imem_req), 64'd1);
                chk("r_wait_addr", imem_addr,     prev_addr);
            end
            if (prev_hold) begin
                chk("r_hold_valid",  64'(inst_valid), 64'd1);
                chk("r_hold_inst",   64'(inst),       64'(prev_inst));
                chk("r_hold_instpc", inst_pc,         prev_pc);
            end
            if (prev_leave) chk("r_leave", 64'(inst_valid), 64'd0);

            imem_ack    = imem_req ? ($urandom_range(99) < 50) : ($urandom_range(99) < 15);
            imem_rdata  = (imem_ack && imem_req) ? mem_f(imem_addr) : $urandom;
            dec_ready   = ($urandom_range(99) < 60);
            redirect    = ($urandom_range(99) < 6);
            redirect_pc = {$urandom, $urandom};
            halt        = 1'b0;

            if (inst_valid && dec_ready) begin
                chk("r_instpc", inst_pc, exp_pc);
                chk("r_inst", 64'(inst), 64'(mem_f(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                delivered++;
            end
            if (redirect) exp_pc = redirect_pc & ~64'h3;

            prev_wait  = imem_req && !imem_ack;
            prev_addr  = imem_addr;
            prev_hold  = inst_valid && !dec_ready && !redirect;
            prev_leave = inst_valid && (dec_ready || redirect);
            prev_inst  = inst;
            prev_pc    = inst_pc;
        end
        chk("r_progress", 64'(delivered >= 50), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
